// File: rtl/rush3d_pkg.sv
// ============================================================================
// Module   : rush3d_pkg
// Brief    : Pixel field positions, lane byte enables and hold-state encoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rush3d_pkg;

  localparam int X_LSB      = 48;
  localparam int Y_LSB      = 32;
  localparam int COLOUR_LSB = 0;
  localparam int COORD_W    = 12;

  localparam logic [7:0] BE_LANE0 = 8'h0F;
  localparam logic [7:0] BE_LANE1 = 8'hF0;
  localparam logic [7:0] BE_FULL  = 8'hFF;

  typedef enum logic {
    HOLD_EMPTY   = 1'b0,
    HOLD_PARTIAL = 1'b1
  } hold_state_e;

endpackage

`default_nettype wire

// File: rtl/pixel_address_calc.sv
// ============================================================================
// Module   : pixel_address_calc
// Brief    : Combinational y*H_RES + x (24-bit wrap) plus an in-bounds flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pixel_address_calc #(
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter bit          SCISSOR_EN = 1'b0
) (
  input  logic [11:0] i_x,
  input  logic [11:0] i_y,
  output logic [23:0] o_pixel_index,
  output logic        o_in_bounds
);

  localparam logic [23:0] C_H_RES_24 = 24'(H_RES);

  assign o_pixel_index = ({12'd0, i_y} * C_H_RES_24) + {12'd0, i_x};

  // Without scissoring every pixel counts as in bounds.
  assign o_in_bounds = !SCISSOR_EN ||
                       ((32'(i_x) < H_RES) && (32'(i_y) < V_RES));

endmodule

`default_nettype wire

// File: rtl/pixel_coalescer.sv
// ============================================================================
// Module   : pixel_coalescer
// Brief    : Merges even/odd-x pixels into 64-bit framebuffer words with BEs.
//            Optional bounds drop: define PIXEL_COALESCER_SCISSOR_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pixel_coalescer
  import rush3d_pkg::*;
#(
  parameter int unsigned H_RES        = 640,
  parameter int unsigned V_RES        = 480,
  parameter int unsigned FLUSH_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [63:0] pixel_data,
  input  logic        pixel_data_valid,
  output logic        pixel_ready,
  input  logic        flush,
  output logic [22:0] word_index,
  output logic [63:0] word_data,
  output logic [7:0]  word_byteenable,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        idle
);

`ifdef PIXEL_COALESCER_SCISSOR_EN
  localparam bit C_SCISSOR_EN = 1'b1;
`else
  localparam bit C_SCISSOR_EN = 1'b0;
`endif

  localparam int                C_CNT_W   = $clog2(FLUSH_CYCLES);
  localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(FLUSH_CYCLES - 1);

  hold_state_e        hold_state_q, hold_state_d;
  logic [22:0]        hold_index_q, hold_index_d;
  logic [63:0]        hold_data_q,  hold_data_d;
  logic [7:0]         hold_be_q,    hold_be_d;
  logic [C_CNT_W-1:0] idle_cnt_q,   idle_cnt_d;
  logic               word_valid_q, word_valid_d;
  logic [22:0]        word_index_q, word_index_d;
  logic [63:0]        word_data_q,  word_data_d;
  logic [7:0]         word_be_q,    word_be_d;

  logic [11:0] w_x, w_y;
  logic [31:0] w_colour;
  logic [23:0] w_pixel_index;
  logic        w_in_bounds;
  logic [22:0] w_word;
  logic        w_lane;
  logic [7:0]  w_lane_be;
  logic [63:0] w_lane_data, w_lane_mask, w_merged;
  logic        w_out_free, w_accept, w_take, w_same_word, w_same_lane, w_timeout;
  logic        w_unused_pad;

  assign w_x          = pixel_data[X_LSB +: COORD_W];
  assign w_y          = pixel_data[Y_LSB +: COORD_W];
  assign w_colour     = pixel_data[COLOUR_LSB +: 32];
  assign w_unused_pad = ^{pixel_data[63:60], pixel_data[47:44]};

  pixel_address_calc #(
    .H_RES      (H_RES),
    .V_RES      (V_RES),
    .SCISSOR_EN (C_SCISSOR_EN)
  ) u_addr (
    .i_x           (w_x),
    .i_y           (w_y),
    .o_pixel_index (w_pixel_index),
    .o_in_bounds   (w_in_bounds)
  );

  assign w_word      = w_pixel_index[23:1];
  assign w_lane      = w_pixel_index[0];
  assign w_lane_be   = w_lane ? BE_LANE1 : BE_LANE0;
  assign w_lane_data = w_lane ? {w_colour, 32'h0} : {32'h0, w_colour};
  assign w_lane_mask = w_lane ? 64'hFFFF_FFFF_0000_0000 : 64'h0000_0000_FFFF_FFFF;
  assign w_merged    = (hold_data_q & ~w_lane_mask) | w_lane_data;

  assign w_out_free  = !word_valid_q || word_ready;
  assign w_accept    = pixel_data_valid && w_out_free && !flush;
  // Dropped (out-of-bounds) pixels are accepted but leave the hold untouched.
  assign w_take      = w_accept && w_in_bounds;
  assign w_same_word = (hold_state_q == HOLD_PARTIAL) && (w_word == hold_index_q);
  assign w_same_lane = (hold_be_q & w_lane_be) != 8'h00;
  assign w_timeout   = idle_cnt_q == C_CNT_MAX;

  always_comb begin
    hold_state_d = hold_state_q;
    hold_index_d = hold_index_q;
    hold_data_d  = hold_data_q;
    hold_be_d    = hold_be_q;
    idle_cnt_d   = idle_cnt_q;
    word_valid_d = word_valid_q && !word_ready;
    word_index_d = word_index_q;
    word_data_d  = word_data_q;
    word_be_d    = word_be_q;

    if (w_take) begin
      idle_cnt_d = '0;
      if (w_same_word && w_same_lane) begin
        hold_data_d = w_merged;
      end else if (w_same_word) begin
        word_valid_d = 1'b1;
        word_index_d = hold_index_q;
        word_data_d  = w_merged;
        word_be_d    = BE_FULL;
        hold_state_d = HOLD_EMPTY;
        hold_be_d    = 8'h00;
      end else begin
        if (hold_state_q == HOLD_PARTIAL) begin
          word_valid_d = 1'b1;
          word_index_d = hold_index_q;
          word_data_d  = hold_data_q;
          word_be_d    = hold_be_q;
        end
        hold_state_d = HOLD_PARTIAL;
        hold_index_d = w_word;
        hold_data_d  = w_lane_data;
        hold_be_d    = w_lane_be;
      end
    end else if (hold_state_q == HOLD_PARTIAL) begin
      if (w_out_free && (flush || w_timeout)) begin
        word_valid_d = 1'b1;
        word_index_d = hold_index_q;
        word_data_d  = hold_data_q;
        word_be_d    = hold_be_q;
        hold_state_d = HOLD_EMPTY;
        hold_be_d    = 8'h00;
        idle_cnt_d   = '0;
      end else if (!w_timeout) begin
        idle_cnt_d = idle_cnt_q + C_CNT_W'(1);
      end
    end else begin
      idle_cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_state_q <= HOLD_EMPTY;
      hold_index_q <= '0;
      hold_data_q  <= '0;
      hold_be_q    <= '0;
      idle_cnt_q   <= '0;
      word_valid_q <= 1'b0;
      word_index_q <= '0;
      word_data_q  <= '0;
      word_be_q    <= '0;
    end else begin
      hold_state_q <= hold_state_d;
      hold_index_q <= hold_index_d;
      hold_data_q  <= hold_data_d;
      hold_be_q    <= hold_be_d;
      idle_cnt_q   <= idle_cnt_d;
      word_valid_q <= word_valid_d;
      word_index_q <= word_index_d;
      word_data_q  <= word_data_d;
      word_be_q    <= word_be_d;
    end
  end

  assign pixel_ready     = w_out_free && !flush;
  assign word_valid      = word_valid_q;
  assign word_index      = word_index_q;
  assign word_data       = word_data_q;
  assign word_byteenable = word_be_q;
  assign idle            = (hold_state_q == HOLD_EMPTY) && !word_valid_q;

endmodule

`default_nettype wire
